// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding and line constants for the serial link
package serial_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic Q_IDLE = 1'b1;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// rtl/serial_tx_bit_timer.sv - bit-period counter, tick marks the last cycle of each bit
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - framed parallel-to-serial transmitter (start, data MSB-first, stop)
module serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             q,
    output logic             busy,
    output logic             done
);

    import serial_pkg::*;

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    idx_next;
    logic             tick;
    logic             accept;
    logic             timer_clear;
    logic             q_next;
    logic             done_next;

    // The timer idles at zero so the first cycle after an accept is count 0.
    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            idx       <= '0;
            q         <= Q_IDLE;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            idx       <= idx_next;
            q         <= q_next;
            done      <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = START;
            START: if (tick) state_next = DATA;
            DATA:  if (tick && idx == IDX_LAST) state_next = STOP;
            STOP:  if (tick) state_next = accept ? START : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // q is registered, so its next value is derived from the same decisions
    // that pick state_next rather than from state_next itself.
    always_comb begin
        busy        = (state != IDLE);
        din_ready   = (state == IDLE) || (state == STOP && tick);
        accept      = din_valid && din_ready;
        timer_clear = (state == IDLE);
        done_next   = (state == STOP) && tick;
        shift_next  = shift_reg;
        idx_next    = idx;
        q_next      = Q_IDLE;

        if (accept) begin
            shift_next = din;
        end else if (state == DATA && tick && idx != IDX_LAST) begin
            shift_next = shift_reg << 1;
        end

        if (state == START && tick) begin
            idx_next = '0;
        end else if (state == DATA && tick && idx != IDX_LAST) begin
            idx_next = idx + IDX_ONE;
        end

        case (state)
            IDLE:  q_next = accept ? 1'b0 : Q_IDLE;
            START: q_next = tick ? shift_reg[WIDTH-1] : 1'b0;
            DATA:  q_next = (tick && idx == IDX_LAST) ? Q_IDLE : shift_next[WIDTH-1];
            STOP:  q_next = (tick && accept) ? 1'b0 : Q_IDLE;
            default: q_next = Q_IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - scoreboard bench for serial_tx across three width/period configurations
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;

    logic q0, busy0, done0, rdy0;
    logic q1, busy1, done1, rdy1;
    logic q2, busy2, done2, rdy2;

    int checks   = 0;
    int failures = 0;
    int sel      = 0;

    // Expected per-cycle record {q, busy, done, din_ready}
    logic [3:0] exp_q[$];
    logic [3:0] act;

    always #5 clk = ~clk;

    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) u_dut0 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(rdy0), .q(q0), .busy(busy0), .done(done0)
    );

    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(rdy1), .q(q1), .busy(busy1), .done(done1)
    );

    serial_tx #(.WIDTH(1), .CLKS_PER_BIT(3)) u_dut2 (
        .clk(clk), .rst(rst), .din(din[0]), .din_valid(din_valid),
        .din_ready(rdy2), .q(q2), .busy(busy2), .done(done2)
    );

    always_comb begin
        case (sel)
            1:       act = {q1, busy1, done1, rdy1};
            2:       act = {q2, busy2, done2, rdy2};
            default: act = {q0, busy0, done0, rdy0};
        endcase
    end

    always begin : monitor
        logic [3:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL stream dut=%0d t=%0t {q,busy,done,ready} actual=%b required=%b",
                         sel, $time, act, e);
            end
        end
    end

    task automatic check(input string name, input logic [3:0] a, input logic [3:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s {q,busy,done,ready} actual=%b required=%b", name, a, e);
        end
    endtask

    task automatic push_frame(input logic [15:0] pat, input int nb, input int c,
                              input logic done0_exp, input int limit);
        int n = 0;
        for (int i = nb - 1; i >= 0; i--) begin
            for (int j = 0; j < c; j++) begin
                if (n < limit)
                    exp_q.push_back({pat[i], 1'b1, (n == 0) & done0_exp, (i == 0 && j == c - 1)});
                n++;
            end
        end
    endtask

    task automatic push_idle(input int n, input logic done_first);
        for (int i = 0; i < n; i++)
            exp_q.push_back({1'b1, 1'b0, (i == 0) & done_first, 1'b1});
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() > 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        repeat (45) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t required=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        din       = 8'h00;
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", act, 4'b1001);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", act, 4'b1001);

        // single 0xA5, din changes after accept
        sel = 0;
        @(negedge clk);
        din = 8'hA5; din_valid = 1'b1;
        push_frame(16'(10'b0101001011), 10, 4, 1'b0, 1000);
        push_idle(4, 1'b1);
        @(negedge clk);
        din_valid = 1'b0; din = 8'h00;
        wait_drain();

        // back-to-back 0x3C then 0xFF with din_valid held
        @(negedge clk);
        din = 8'h3C; din_valid = 1'b1;
        push_frame(16'(10'b0001111001), 10, 4, 1'b0, 1000);
        push_frame(16'(10'b0111111111), 10, 4, 1'b1, 1000);
        push_idle(4, 1'b1);
        @(negedge clk);
        din = 8'hFF;
        repeat (40) @(negedge clk);
        din_valid = 1'b0;
        wait_drain();

        // valid pulse mid-frame is ignored
        @(negedge clk);
        din = 8'hA5; din_valid = 1'b1;
        push_frame(16'(10'b0101001011), 10, 4, 1'b0, 1000);
        push_idle(4, 1'b1);
        @(negedge clk);
        din_valid = 1'b0;
        repeat (11) @(negedge clk);
        din = 8'h00; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        wait_drain();

        // reset mid-DATA abandons the frame, then 0x81
        @(negedge clk);
        din = 8'hA5; din_valid = 1'b1;
        push_frame(16'(10'b0101001011), 10, 4, 1'b0, 10);
        @(negedge clk);
        din_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        push_idle(6, 1'b0);
        #1;
        check("async_reset_mid_data", act, 4'b1001);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_drain();
        @(negedge clk);
        din = 8'h81; din_valid = 1'b1;
        push_frame(16'(10'b0100000011), 10, 4, 1'b0, 1000);
        push_idle(4, 1'b1);
        @(negedge clk);
        din_valid = 1'b0;
        wait_drain();

        // CLKS_PER_BIT=1, 0x80
        sel = 1;
        @(negedge clk);
        check("dut1_idle", act, 4'b1001);
        din = 8'h80; din_valid = 1'b1;
        push_frame(16'(10'b0100000001), 10, 1, 1'b0, 1000);
        push_idle(4, 1'b1);
        @(negedge clk);
        din_valid = 1'b0;
        wait_drain();

        // WIDTH=1, CLKS_PER_BIT=3, data 1
        sel = 2;
        @(negedge clk);
        check("dut2_idle", act, 4'b1001);
        din = 8'h01; din_valid = 1'b1;
        push_frame(16'(3'b011), 3, 3, 1'b0, 1000);
        push_idle(4, 1'b1);
        @(negedge clk);
        din_valid = 1'b0;
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
# serial_tx

Parallel-in, serial-out frame transmitter. It is the driving end of the single-bit serial line that the team's shift-register capture stages (blocking and non-blocking flip-flop chains) sample. It accepts a WIDTH-bit word over a valid/ready handshake and drives it onto one output bit as a framed stream: start bit, data MSB-first, then stop bit. Each bit is held for CLKS_PER_BIT clocks.

## Interface
- WIDTH, 8: data bits per frame, ≥1
- CLKS_PER_BIT, 4: clock cycles each serial bit is held, ≥1
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- din  in  WIDTH  parallel word to send; sampled only on handshake
- din_valid  in  1  din holds a word to send
- din_ready  out  1  transmitter can accept a word this cycle
- q  out  1  serial line; idle level 1
- busy  out  1  a frame is in progress (START/DATA/STOP)
- done  out  1  one-cycle pulse, the cycle after a stop bit completes

## Operation
- States: IDLE, START, DATA, STOP.
- Handshake: a word is accepted on a rising edge where din_valid && din_ready are both high. din is copied into the internal shift register at that edge. Later changes on din have no effect on the frame in flight.
- din_ready is high in IDLE, and in the last cycle of STOP (back-to-back support). It is low otherwise. din_valid while din_ready is low is ignored: no queuing.
- IDLE: q=1, busy=0. On accept, go to START.
- START: q=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: q = shift_reg[WIDTH-1]. Every CLKS_PER_BIT cycles, shift left by 1 and increment the bit index. After WIDTH bits, go to STOP.
- STOP: q=1 for CLKS_PER_BIT cycles.
  - If a word is accepted in the last STOP cycle, go to START.
  - Otherwise go to IDLE.
- done is registered. It is high for exactly one cycle, the cycle after the last STOP cycle, whether the next state is IDLE or START.
- busy = (state != IDLE).
- Counters:
  - Bit-period counter: $clog2(CLKS_PER_BIT) bits, minimum 1. Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Bit index: $clog2(WIDTH) bits, minimum 1. Counts 0..WIDTH-1 only. It is cleared on entry to DATA.
- Reset (asynchronous, any time, including mid-frame):
  - state=IDLE, q=1, busy=0, done=0, din_ready=1.
  - Counters and shift register are cleared.
  - The partial frame is abandoned; no done pulse is produced for it.

## Timing
- Define the accept edge as cycle 0.
- q=0 from cycle 1 through CLKS_PER_BIT.
- Data bit k (k=0 is the MSB) occupies cycles 1+(k+1)·CLKS_PER_BIT through (k+2)·CLKS_PER_BIT.
- Stop bit occupies the last CLKS_PER_BIT cycles of the frame.
- Frame length is (WIDTH+2)·CLKS_PER_BIT cycles. done is high at cycle (WIDTH+2)·CLKS_PER_BIT+1.
- Back-to-back words leave zero idle cycles between the stop bit and the next start bit.
- q and done are driven directly from flops; there is no combinational path from din or din_valid to q.

## Structure
- Shared package (serial_pkg) holds:
  - state encoding localparams: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3
  - the q idle-level constant (1'b1)
- The receiving side reuses this package.
- One sub-module, bit_timer:
  - parameter CLKS_PER_BIT
  - ports: clk, rst, clear, tick
  - tick is high in the last cycle of each bit period.

## Test plan
- WIDTH=8, CLKS_PER_BIT=4; send 0xA5 (single din_valid pulse, cycle 0) -> q holds 0,1,0,1,0,0,1,0,1,1 for 4 cycles each over cycles 1–40; busy high cycles 1–40; done high only at cycle 41; din_ready high again at cycle 40.
- Hold din_valid high with 0x3C then 0xFF -> second accept at cycle 40; second start bit begins cycle 41 with no idle-high gap; done pulses at cycle 41 and cycle 81.
- Pulse din_valid with din=0x00 at cycle 12 during a 0xA5 frame -> ignored; q stream identical to the first test; exactly one done.
- Assert rst at cycle 10 mid-DATA -> q=1, busy=0, din_ready=1 before the next edge; no done pulse; a new 0x81 sent after release is framed correctly.
- CLKS_PER_BIT=1, WIDTH=8, send 0x80 -> 10-cycle frame q=0,1,0,0,0,0,0,0,0,1; done at cycle 11.
- WIDTH=1, CLKS_PER_BIT=3, send 1'b1 -> q=0 for cycles 1–3, 1 for 4–6, 1 (stop) for 7–9; done at cycle 10.
